secded_block_decoder: RTL

- Parametrised extended-Hamming (SECDED) decode engine that replaces the fixed 11-bit program-2 datapath.
- On start, it reads N_MSG codewords from byte-wide data memory at IN_BASE, then checks and corrects each one.
- It writes the flagged data words to OUT_BASE and raises done.
- Data width and message count are generic. It also adds a one-cycle syndrome pipeline stage and optional error statistics.

---
 rtl/secded_pkg.sv | 48 ++++
 rtl/secded_block_decoder_if.sv | 19 +
 rtl/secded_decode_core.sv | 56 +++++
 rtl/secded_block_decoder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/secded_pkg.sv
// Shared types and width helpers for the SECDED block decoder.
// The STATS state exists only when SECDED_STATS_EN is defined.
package secded_pkg;

    typedef enum logic [1:0] {
        FLAG_CLEAN = 2'b00,
        FLAG_CORR  = 2'b01,
        FLAG_DBL   = 2'b10
    } flag_e;

`ifdef SECDED_STATS_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DECODE,
        ST_WRITE,
        ST_STATS,
        ST_DONE
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DECODE,
        ST_WRITE,
        ST_DONE
    } state_e;
`endif

    // Legal payload widths 4, 11, 26 map onto 8, 16, 32-bit codewords.
    function automatic int cw_width(input int data_w);
        if (data_w <= 4)
            return 8;
        else if (data_w <= 11)
            return 16;
        return 32;
    endfunction

    // Index of the highest p(2^k) bit; the syndrome is one bit wider.
    function automatic int parity_count(input int data_w);
        return $clog2(cw_width(data_w)) - 1;
    endfunction

    function automatic int bytes_per_word(input int data_w);
        return cw_width(data_w) / 8;
    endfunction

endpackage

// File: rtl/secded_block_decoder_if.sv
// Start/done handshake plus the byte-wide data-memory port of the decoder.
interface secded_block_decoder_if;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic [7:0] mem_wr_data;
    logic       mem_wr_en;

    modport master (
        input  start, mem_rd_data,
        output done, mem_addr, mem_wr_data, mem_wr_en
    );

    modport slave (
        output start, mem_rd_data,
        input  done, mem_addr, mem_wr_data, mem_wr_en
    );
endinterface

// File: rtl/secded_decode_core.sv
// Combinational extended-Hamming check/correct: codeword in, {flag, data} out.
module secded_decode_core
    import secded_pkg::*;
#(
    parameter int DATA_W = 11
) (
    input  logic [cw_width(DATA_W)-1:0] codeword,
    output flag_e                       flag,
    output logic [DATA_W-1:0]           data
);
    localparam int CW = cw_width(DATA_W);
    localparam int SW = parity_count(DATA_W) + 1;

    logic [SW-1:0] syndrome;
    logic          overall;
    logic [CW-1:0] fixed;
    logic [CW-1:0] work;
    int            k;

    // NOTE: every variable gets a value before any branch, so no latch is inferred.
    always_comb begin
        syndrome = '0;
        overall  = 1'b0;
        data     = '0;
        k        = 0;

        work = codeword;
        for (int i = 0; i < CW; i++) begin
            if (work[0]) begin
                overall  = ~overall;
                syndrome = syndrome ^ SW'(i);
            end
            work = work >> 1;
        end

        // Odd overall parity means one flip at position s (s=0 is p0 itself).
        fixed = codeword ^ (CW'(overall) << syndrome);

        if (overall)
            flag = FLAG_CORR;
        else if (syndrome != '0)
            flag = FLAG_DBL;
        else
            flag = FLAG_CLEAN;

        work = fixed;
        for (int i = 0; i < CW; i++) begin
            if ((i & (i - 1)) != 0) begin
                data = data | (DATA_W'(work[0]) << k);
                k++;
            end
            work = work >> 1;
        end
    end

endmodule

// File: rtl/secded_block_decoder.sv
// SECDED block decoder: reads N_MSG codewords, corrects them, writes flagged words.
// Define SECDED_STATS_EN to add clean/corrected/uncorrectable counters written at STATS_ADDR.
module secded_block_decoder
    import secded_pkg::*;
#(
    parameter int DATA_W     = 11,
    parameter int N_MSG      = 15,
    parameter int IN_BASE    = 30,
    parameter int OUT_BASE   = 0,
    parameter int STATS_ADDR = 64
) (
    input  logic                   clock,
    input  logic                   reset_n,
    secded_block_decoder_if.master bus
);
    localparam int CW    = cw_width(DATA_W);
    localparam int B     = bytes_per_word(DATA_W);
    localparam int IDX_W = (N_MSG > 1) ? $clog2(N_MSG) : 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       byte_q, byte_d, byte_nxt;
    logic [CW-1:0]    cw_q, cw_d;
    logic [CW-1:0]    word_q, word_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             wr_en_q, wr_en_d;
    logic             done_q, done_d;
    logic             last_byte, last_msg;

    flag_e            core_flag;
    logic [DATA_W-1:0] core_data;
    logic [CW-1:0]    core_word;

`ifdef SECDED_STATS_EN
    logic [7:0] n_clean_q, n_clean_d;
    logic [7:0] n_corr_q, n_corr_d;
    logic [7:0] n_dbl_q, n_dbl_d;
`endif

    secded_decode_core #(.DATA_W(DATA_W)) u_core (
        .codeword (cw_q),
        .flag     (core_flag),
        .data     (core_data)
    );

    assign core_word = (CW'(core_flag) << (CW - 2)) | CW'(core_data);
    assign byte_nxt  = byte_q + 2'd1;
    assign last_byte = (byte_q == 2'(B - 1));
    assign last_msg  = (idx_q == IDX_W'(N_MSG - 1));

    // Byte addresses wrap modulo 256 by truncation.
    function automatic logic [7:0] in_addr(input int i, input int j);
        return 8'(IN_BASE + B * i + j);
    endfunction

    function automatic logic [7:0] out_addr(input int i, input int j);
        return 8'(OUT_BASE + B * i + j);
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        cw_d    = cw_q;
        word_d  = word_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_en_d = 1'b0;
        done_d  = done_q;
`ifdef SECDED_STATS_EN
        n_clean_d = n_clean_q;
        n_corr_d  = n_corr_q;
        n_dbl_d   = n_dbl_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d = ST_READ;
                    done_d  = 1'b0;
                    idx_d   = '0;
                    byte_d  = '0;
                    addr_d  = in_addr(0, 0);
`ifdef SECDED_STATS_EN
                    n_clean_d = '0;
                    n_corr_d  = '0;
                    n_dbl_d   = '0;
`endif
                end
            end

            ST_READ: begin
                cw_d = (cw_q & ~(CW'(8'hFF) << (8 * int'(byte_q))))
                     | (CW'(bus.mem_rd_data) << (8 * int'(byte_q)));
                if (last_byte) begin
                    state_d = ST_DECODE;
                    byte_d  = '0;
                end else begin
                    byte_d = byte_nxt;
                    addr_d = in_addr(int'(idx_q), int'(byte_nxt));
                end
            end

            ST_DECODE: begin
                word_d  = core_word;
                state_d = ST_WRITE;
                byte_d  = '0;
                wr_en_d = 1'b1;
                addr_d  = out_addr(int'(idx_q), 0);
                wdata_d = core_word[7:0];
`ifdef SECDED_STATS_EN
                case (core_flag)
                    FLAG_CLEAN: if (n_clean_q != 8'hFF) n_clean_d = n_clean_q + 8'd1;
                    FLAG_CORR:  if (n_corr_q != 8'hFF)  n_corr_d  = n_corr_q + 8'd1;
                    default:    if (n_dbl_q != 8'hFF)   n_dbl_d   = n_dbl_q + 8'd1;
                endcase
`endif
            end

            ST_WRITE: begin
                if (last_byte) begin
                    byte_d = '0;
                    if (last_msg) begin
`ifdef SECDED_STATS_EN
                        state_d = ST_STATS;
                        wr_en_d = 1'b1;
                        addr_d  = 8'(STATS_ADDR);
                        wdata_d = n_clean_q;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = ST_READ;
                        idx_d   = idx_q + IDX_W'(1);
                        addr_d  = in_addr(int'(idx_q) + 1, 0);
                    end
                end else begin
                    byte_d  = byte_nxt;
                    wr_en_d = 1'b1;
                    addr_d  = out_addr(int'(idx_q), int'(byte_nxt));
                    wdata_d = 8'(word_q >> (8 * int'(byte_nxt)));
                end
            end

`ifdef SECDED_STATS_EN
            ST_STATS: begin
                if (byte_q == 2'd2) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    byte_d  = '0;
                end else begin
                    byte_d  = byte_nxt;
                    wr_en_d = 1'b1;
                    addr_d  = 8'(STATS_ADDR + int'(byte_nxt));
                    wdata_d = (byte_nxt == 2'd1) ? n_corr_q : n_dbl_q;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            byte_q  <= '0;
            cw_q    <= '0;
            word_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef SECDED_STATS_EN
            n_clean_q <= '0;
            n_corr_q  <= '0;
            n_dbl_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            cw_q    <= cw_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_en_q <= wr_en_d;
            done_q  <= done_d;
`ifdef SECDED_STATS_EN
            n_clean_q <= n_clean_d;
            n_corr_q  <= n_corr_d;
            n_dbl_q   <= n_dbl_d;
`endif
        end
    end

    assign bus.done        = done_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wdata_q;
    assign bus.mem_wr_en   = wr_en_q;

endmodule
